fa_resp_checker: RTL and testbench

Synchronous response checker that sits on the output side of a full-adder under test. It accepts one input vector per handshake, waits a programmable settle time, then samples the DUT's Sum/Carry and compares them against the arithmetic result. It keeps pass/fail, error-count and coverage state, so an exhaustive 8-vector sweep can be graded in hardware rather than by waveform inspection.

---
 rtl/fa_resp_checker.sv | 148 ++++++++++++++
 tb/tb_fa_resp_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fa_resp_checker.sv
// Response checker for a full-adder under test: accepts a vector, waits SETTLE cycles,
// grades {Carry,Sum} against x+y+cin. Optional first-mismatch capture: FA_CHK_FIRSTFAIL_EN.
module fa_resp_checker #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             x,
    input  logic             y,
    input  logic             cin,
    input  logic             Sum,
    input  logic             Carry,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [7:0]       cov_mask,
    output logic             all_covered,
    output logic [4:0]       first_fail,
    output logic             first_fail_vld
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [2:0] vec_q;
    logic [1:0] expected;
    logic       mismatch;
    logic       accept;
    logic       check_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept    = (state == ST_IDLE) && vec_valid;
    assign check_now = (state == ST_CHECK);
    assign expected  = 2'(vec_q[2]) + 2'(vec_q[1]) + 2'(vec_q[0]);
    assign mismatch  = ({Carry, Sum} != expected);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (vec_valid) begin
                    state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_ready = (state == ST_IDLE);
    end

    // Settle countdown is reloaded every idle cycle so it is ready at acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wait_cnt <= SETTLE_CNT;
        end else if (state == ST_SETTLE) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q <= {x, y, cin};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            pass <= check_now && !mismatch;
            fail <= check_now && mismatch;
        end
    end

    // Clear takes priority over a same-cycle check; the pulse above is unaffected.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            err_cnt  <= '0;
            chk_cnt  <= '0;
            cov_mask <= '0;
        end else if (check_now) begin
            chk_cnt         <= sat_inc(chk_cnt);
            cov_mask[vec_q] <= 1'b1;
            if (mismatch) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    assign all_covered = &cov_mask;

`ifdef FA_CHK_FIRSTFAIL_EN
    logic [4:0] ff_q;
    logic       ffv_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            ff_q  <= '0;
            ffv_q <= 1'b0;
        end else if (check_now && mismatch && !ffv_q) begin
            ff_q  <= {vec_q, Carry, Sum};
            ffv_q <= 1'b1;
        end
    end

    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
`else
    assign first_fail     = 5'd0;
    assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_fa_resp_checker.sv
// Randomized bench for fa_resp_checker: two instances (SETTLE=2/CNT_W=8 and SETTLE=0/CNT_W=2)
// graded against a transaction-level reference model.
module tb_fa_resp_checker;

    logic clk = 1'b0;
    logic reset_n, clr, vec_valid, x, y, cin, Sum, Carry;
    logic sel;

    logic       rdy_a, pass_a, fail_a, allc_a, ffv_a;
    logic [7:0] err_a, chk_a, cov_a;
    logic [4:0] ff_a;
    logic       rdy_b, pass_b, fail_b, allc_b, ffv_b;
    logic [1:0] err_b, chk_b;
    logic [7:0] cov_b;
    logic [4:0] ff_b;

    logic       vec_ready, pass, fail, all_covered, first_fail_vld;
    logic [7:0] err_cnt, chk_cnt, cov_mask;
    logic [4:0] first_fail;

    int n_checks = 0;
    int n_errors = 0;

    int         settle_cur, cnt_max, m_err, m_chk;
    logic [7:0] m_cov;
    logic [4:0] m_ff;
    bit         m_ffv;

    always #5 clk = ~clk;

    fa_resp_checker #(.SETTLE(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .clr(clr), .vec_valid(vec_valid & ~sel),
        .vec_ready(rdy_a), .x(x), .y(y), .cin(cin), .Sum(Sum), .Carry(Carry),
        .pass(pass_a), .fail(fail_a), .err_cnt(err_a), .chk_cnt(chk_a),
        .cov_mask(cov_a), .all_covered(allc_a), .first_fail(ff_a), .first_fail_vld(ffv_a)
    );

    fa_resp_checker #(.SETTLE(0), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .clr(clr), .vec_valid(vec_valid & sel),
        .vec_ready(rdy_b), .x(x), .y(y), .cin(cin), .Sum(Sum), .Carry(Carry),
        .pass(pass_b), .fail(fail_b), .err_cnt(err_b), .chk_cnt(chk_b),
        .cov_mask(cov_b), .all_covered(allc_b), .first_fail(ff_b), .first_fail_vld(ffv_b)
    );

    always_comb begin
        vec_ready      = sel ? rdy_b  : rdy_a;
        pass           = sel ? pass_b : pass_a;
        fail           = sel ? fail_b : fail_a;
        err_cnt        = sel ? {6'd0, err_b} : err_a;
        chk_cnt        = sel ? {6'd0, chk_b} : chk_a;
        cov_mask       = sel ? cov_b  : cov_a;
        all_covered    = sel ? allc_b : allc_a;
        first_fail     = sel ? ff_b   : ff_a;
        first_fail_vld = sel ? ffv_b  : ffv_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fa_sum(input logic [2:0] v);
        return int'(v[2]) + int'(v[1]) + int'(v[0]);
    endfunction

    // Response of the adder under test; fault 1 = Carry stuck-at-0, fault 2 = corrupted output.
    function automatic logic [1:0] fa_resp(input logic [2:0] v, input int fault);
        logic [1:0] r;
        r = 2'(fa_sum(v));
        if (fault == 1) r[1] = 1'b0;
        if (fault == 2) r = r ^ 2'($urandom_range(1, 3));
        return r;
    endfunction

    task automatic model_clear();
        m_err = 0; m_chk = 0; m_cov = 8'd0; m_ff = 5'd0; m_ffv = 1'b0;
    endtask

    task automatic check_state(input string pfx);
        check({pfx, "_err"},  err_cnt, m_err);
        check({pfx, "_chk"},  chk_cnt, m_chk);
        check({pfx, "_cov"},  cov_mask, m_cov);
        check({pfx, "_allc"}, all_covered, (m_cov == 8'hFF));
        check({pfx, "_ff"},   first_fail, m_ff);
        check({pfx, "_ffv"},  first_fail_vld, m_ffv);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_clear();
    endtask

    task automatic run_vec(input logic [2:0] v, input int fault, input bit hold, input bit clr_chk);
        logic [1:0] resp;
        bit         mis, got;
        int         n;
        resp = fa_resp(v, fault);
        mis  = (resp != 2'(fa_sum(v)));
        check("idle_ready", vec_ready, 1);
        {x, y, cin}  = v;
        {Carry, Sum} = resp;
        vec_valid    = 1'b1;
        @(posedge clk); #1;
        if (!hold) vec_valid = 1'b0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            clr = clr_chk && (n == settle_cur);
            if (hold) {x, y, cin} = 3'($urandom);
            @(posedge clk); #1;
            n++;
            if (pass || fail) got = 1;
            else check("busy_ready", vec_ready, 0);
        end
        clr = 1'b0;
        vec_valid = 1'b0;
        if (clr_chk) begin
            model_clear();
        end else begin
            m_chk = (m_chk < cnt_max) ? m_chk + 1 : cnt_max;
            if (mis) m_err = (m_err < cnt_max) ? m_err + 1 : cnt_max;
            m_cov[v] = 1'b1;
`ifdef FA_CHK_FIRSTFAIL_EN
            if (mis && !m_ffv) begin
                m_ff  = {v, resp};
                m_ffv = 1'b1;
            end
`endif
        end
        check("latency", n, settle_cur + 1);
        check("pass", pass, !mis);
        check("fail", fail, mis);
        check("ready_back", vec_ready, 1);
        check_state("post");
    endtask

    initial begin
        sel = 1'b0; settle_cur = 2; cnt_max = 255;
        reset_n = 1'b0; clr = 1'b0; vec_valid = 1'b0;
        x = 0; y = 0; cin = 0; Sum = 0; Carry = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", vec_ready, 1);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check_state("rst");
        check("rst_ready_b", rdy_b, 1);
        reset_n = 1'b1;

        // Exhaustive sweep, fault-free adder
        for (int v = 0; v < 8; v++) run_vec(3'(v), 0, 0, 0);
        check("sweep_err", err_cnt, 0);
        check("sweep_chk", chk_cnt, 8);
        check("sweep_cov", cov_mask, 8'hFF);
        check("sweep_allc", all_covered, 1);

        // Carry stuck-at-0, first-fail capture then no overwrite
        do_clr();
        run_vec(3'b110, 1, 0, 0);
        check("stuck_err", err_cnt, 1);
`ifdef FA_CHK_FIRSTFAIL_EN
        check("stuck_ff", first_fail, 5'b110_00);
        check("stuck_ffv", first_fail_vld, 1);
`endif
        run_vec(3'b111, 1, 0, 0);
        check("stuck_err2", err_cnt, 2);
`ifdef FA_CHK_FIRSTFAIL_EN
        check("stuck_ff2", first_fail, 5'b110_00);
`endif

        // vec_valid held with a changing vector while busy
        do_clr();
        run_vec(3'b011, 0, 1, 0);
        check("hold_chk", chk_cnt, 1);
        check("hold_cov", cov_mask, 8'b0000_1000);

        // clr coincident with the check edge
        run_vec(3'b101, 2, 0, 1);
        check("clr_err", err_cnt, 0);
        check("clr_chk", chk_cnt, 0);
        check("clr_cov", cov_mask, 0);

        // Reset during SETTLE discards the in-flight check
        run_vec(3'b000, 2, 0, 0);
        check("vec_ready", vec_ready, 1);
        {x, y, cin} = 3'b111; {Carry, Sum} = 2'b00; vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        model_clear();
        check("mrst_ready", vec_ready, 1);
        check("mrst_pass", pass, 0);
        check("mrst_fail", fail, 0);
        check_state("mrst");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mrst_nopulse", pass | fail, 0);
        end

        for (int i = 0; i < 40; i++) begin
            run_vec(3'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        // Zero-settle, 2-bit counter instance
        sel = 1'b1; settle_cur = 0; cnt_max = 3;
        do_clr();
        run_vec(3'b001, 0, 0, 0);
        for (int i = 0; i < 5; i++) run_vec(3'(i), 2, 0, 0);
        check("sat_err", err_cnt, 3);
        check("sat_chk", chk_cnt, 3);
        for (int i = 0; i < 30; i++) begin
            run_vec(3'($urandom), ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : 0,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
